unary_decode_u: RTL and testbench

Unipolar unary-to-binary decoder for the unary kernel library. Counts ones on a single stochastic bitstream (e.g. a divider's `quotient`) over a fixed window of 2^DEP cycles. Presents the count as a binary word through a valid/ready output handshake. This is the receiving end that turns kernel output streams back into binary values for checking and for downstream binary logic.

---
 rtl/unary_pkg.sv | 16 +
 rtl/unary_decode_u_win_cnt.sv | 24 ++
 rtl/unary_decode_u.sv | 87 ++++++++
 tb/tb_unary_decode_u.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary kernel library's binary decoders.
package unary_pkg;

  // Decoder control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } udec_state_t;

  // Window length in cycles for a given log2 depth.
  function automatic int unsigned win_len(input int unsigned dep);
    return 32'd1 << dep;
  endfunction

endpackage

// File: rtl/unary_decode_u_win_cnt.sv
// win_cnt: W-bit clearable up-counter with a flag that marks the all-ones count.
module win_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  // Count register: clear has priority over increment.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  // All ones marks the final sample of the window.
  assign last = &count;

endmodule

// File: rtl/unary_decode_u.sv
// unary_decode_u: counts ones on a unipolar stochastic bitstream over 2^DEP
// cycles and presents the count through a valid/ready handshake.
module unary_decode_u
  import unary_pkg::*;
#(
  parameter int DEP = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           in_bit,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DEP:0]   out_data
);

  udec_state_t    state_q, state_d;
  logic [DEP-1:0] wcnt;
  logic           wlast;
  logic [DEP:0]   acc;
  logic           handshake;
  logic           accept;
  logic [DEP:0]   in_ext;

  assign handshake = out_valid & out_ready;
  // A new window begins from IDLE, or straight out of HOLD on the handshake cycle.
  assign accept    = start & ((state_q == IDLE) | ((state_q == HOLD) & handshake));
  assign in_ext    = {{DEP{1'b0}}, in_bit};

  win_cnt #(.W(DEP)) u_wcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state_q == ACCUM),
    .count (wcnt),
    .last  (wlast)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start outside IDLE or a HOLD handshake is ignored.
  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (wlast) state_d = HOLD;
      HOLD:    if (handshake) state_d = start ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: busy follows the state register directly.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Ones accumulator; max 2^DEP fits in DEP+1 bits, so no overflow handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 acc <= '0;
    else if (accept)            acc <= '0;
    else if (state_q == ACCUM)  acc <= acc + in_ext;
  end

  // Result register: captures on the last sample, holds until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if ((state_q == ACCUM) && wlast) begin
      out_valid <= 1'b1;
      out_data  <= acc + in_ext;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

  unused_wcnt_ok: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != ACCUM) || (acc <= {1'b0, wcnt}))
    else $error("accumulator exceeds sample count");

endmodule

// File: tb/tb_unary_decode_u.sv
// Directed bench for unary_decode_u with DEP=5 (32-cycle window).
module tb_unary_decode_u;
  import unary_pkg::*;

  localparam int          DEP = 5;
  localparam int unsigned WIN = win_len(DEP);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_bit = 1'b0;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         out_valid;
  logic [DEP:0] out_data;

  int errors = 0;
  int checks = 0;

  unary_decode_u #(.DEP(DEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_bit    (in_bit),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a window (optionally as a HOLD handshake) and feeds samples until out_valid.
  // kind: 0 all ones, 1 all zeros, 2 alternating 1,0, 3 Bernoulli(0.25).
  // n counts edges from the accepting edge to the first cycle out_valid is seen.
  task automatic run_window(input string tag, input bit with_hs, input int kind,
                            input bit start_bit, input int mid_start,
                            output int n, output int ones);
    logic b;
    start     = 1'b1;
    in_bit    = start_bit;
    out_ready = with_hs;
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b0;
    n         = 1;
    ones      = 0;
    if (with_hs) check({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < int'(WIN) + 8; i++) begin
      case (kind)
        0:       b = 1'b1;
        1:       b = 1'b0;
        2:       b = (i % 2 == 0);
        default: b = ($urandom_range(3) == 0);
      endcase
      if (i < int'(WIN)) ones += int'(b);
      in_bit = b;
      start  = (i == mid_start);
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (out_valid) break;
    end
    in_bit = 1'b0;
  endtask

  task automatic handshake(input string tag, input logic [DEP:0] exp_data);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " hs valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " hs busy"},  {31'd0, busy},      32'd0);
    check({tag, " hs keep"},  {26'd0, out_data},  {26'd0, exp_data});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ones, sum;

    // Reset and idle.
    repeat (2) @(posedge clk);
    #1;
    check("rst busy",  {31'd0, busy},      32'd0);
    check("rst valid", {31'd0, out_valid}, 32'd0);
    check("rst data",  {26'd0, out_data},  32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle busy",  {31'd0, busy},      32'd0);
      check("idle valid", {31'd0, out_valid}, 32'd0);
      check("idle data",  {26'd0, out_data},  32'd0);
    end

    // All ones: full-scale result, MSB only.
    run_window("ones", 1'b0, 0, 1'b0, -1, n, ones);
    check("ones lat",  n, 33);
    check("ones data", {26'd0, out_data}, 32'd32);
    check("ones busy", {31'd0, busy}, 32'd1);
    handshake("ones", 6'd32);

    // All zeros.
    run_window("zeros", 1'b0, 1, 1'b1, -1, n, ones);
    check("zeros lat",  n, 33);
    check("zeros data", {26'd0, out_data}, 32'd0);
    handshake("zeros", 6'd0);

    // Alternating with in_bit=1 on the start cycle: start-cycle bit excluded.
    run_window("alt", 1'b0, 2, 1'b1, -1, n, ones);
    check("alt lat",  n, 33);
    check("alt data", {26'd0, out_data}, 32'd16);

    // Stall in HOLD: inputs wiggle, result and busy stay put.
    for (int i = 0; i < 20; i++) begin
      in_bit = ~in_bit;
      start  = in_bit;
      @(posedge clk); #1;
      check("stall data",  {26'd0, out_data},  32'd16);
      check("stall valid", {31'd0, out_valid}, 32'd1);
      check("stall busy",  {31'd0, busy},      32'd1);
    end
    start  = 1'b0;
    in_bit = 1'b0;

    // Back-to-back: handshake with start, new window straight away.
    run_window("b2b", 1'b1, 0, 1'b1, -1, n, ones);
    check("b2b lat",  n, 33);
    check("b2b data", {26'd0, out_data}, 32'd32);
    handshake("b2b", 6'd32);

    // start pulsed mid-window is ignored.
    run_window("mid", 1'b0, 2, 1'b0, 10, n, ones);
    check("mid lat",  n, 33);
    check("mid data", {26'd0, out_data}, 32'd16);
    handshake("mid", 6'd16);

    // Asynchronous reset after 17 samples.
    start  = 1'b1;
    in_bit = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("pre-rst busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst busy",  {31'd0, busy},      32'd0);
    check("arst valid", {31'd0, out_valid}, 32'd0);
    check("arst data",  {26'd0, out_data},  32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    in_bit = 1'b0;
    run_window("post-rst", 1'b0, 0, 1'b0, -1, n, ones);
    check("post-rst lat",  n, 33);
    check("post-rst data", {26'd0, out_data}, 32'd32);
    handshake("post-rst", 6'd32);

    // Bernoulli(0.25): exact per-window count and mean near 8.
    sum = 0;
    for (int w = 0; w < 100; w++) begin
      run_window("bern", 1'b0, 3, 1'b0, -1, n, ones);
      check("bern lat",  n, 33);
      check("bern data", {26'd0, out_data}, ones);
      sum += int'(out_data);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    check("bern mean", {31'd0, (sum >= 700 && sum <= 900)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
